// File: rtl/ttr_pkg.sv
// Shared TTR definitions: phase encoding and frame length, used by the voter and
// by the TTR flip-flop blocks that consume the phase.
package ttr_pkg;

    typedef logic [1:0] phase_t;

    localparam phase_t PH0 = 2'd0;
    localparam phase_t PH1 = 2'd1;
    localparam phase_t PH2 = 2'd2;

    localparam int TTR_N = 3;

    // Wraps after the last of TTR_N phases; the unused code 3 also recovers to PH0.
    function automatic phase_t next_phase(input phase_t p);
        if (int'(p) >= TTR_N - 1) begin
            return PH0;
        end
        return p + 2'd1;
    endfunction

endpackage

// File: rtl/ttr_maj3.sv
// Bitwise 2-of-3 majority with all-equal / none-equal flags.
// Purely combinational, no latency, no flow control.
module ttr_maj3 #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] maj,
    output logic         all_eq,
    output logic         none_eq
);

    assign maj     = (a & b) | (a & c) | (b & c);
    assign all_eq  = (a == b) && (b == c);
    assign none_eq = (a != b) && (a != c) && (b != c);

endmodule

// File: rtl/ttr_vote_ctrl.sv
// TTR phase driver and 3-sample voter: one voted word per 3-phase frame.
// Result appears 1 clk after the PH2 capture; en=0 stalls the frame, no other backpressure.
module ttr_vote_ctrl
    import ttr_pkg::*;
#(
    parameter int W      = 1,
    parameter int ECNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr_err,
    input  logic [W-1:0]      inD,
    output logic [1:0]        ctr,
    output logic [W-1:0]      outD,
    output logic              outValid,
    output logic              errDet,
    output logic              errFatal,
    output logic              errSticky,
    output logic [ECNT_W-1:0] errCnt
);

    phase_t         phase;
    logic [W-1:0]   s0;
    logic [W-1:0]   s1;
    logic [W-1:0]   vote;
    logic           all_eq;
    logic           none_eq;
    logic           frame_done;
    logic           det_now;
    logic           fatal_now;

    // Third sample is taken straight from inD, so the vote is ready on the PH2 edge.
    ttr_maj3 #(
        .W (W)
    ) u_maj3 (
        .a       (s0),
        .b       (s1),
        .c       (inD),
        .maj     (vote),
        .all_eq  (all_eq),
        .none_eq (none_eq)
    );

    assign frame_done = en && (phase == PH2);
    assign det_now    = frame_done && !all_eq && !none_eq;
    assign fatal_now  = frame_done && none_eq;
    assign ctr        = phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= PH0;
            s0       <= '0;
            s1       <= '0;
            outD     <= '0;
            outValid <= 1'b0;
            errDet   <= 1'b0;
            errFatal <= 1'b0;
        end else begin
            outValid <= frame_done;
            errDet   <= det_now;
            errFatal <= fatal_now;
            if (en) begin
                phase <= next_phase(phase);
                if (phase == PH0) begin
                    s0 <= inD;
                end
                if (phase == PH1) begin
                    s1 <= inD;
                end
                if (phase == PH2) begin
                    outD <= vote;
                end
            end
        end
    end

    // Clear beats a coincident error; the error pulses themselves still go out.
    always_ff @(posedge clk) begin
        if (rst) begin
            errCnt    <= '0;
            errSticky <= 1'b0;
        end else if (clr_err) begin
            errCnt    <= '0;
            errSticky <= 1'b0;
        end else begin
            if (det_now && (errCnt != {ECNT_W{1'b1}})) begin
                errCnt <= errCnt + 1'b1;
            end
            if (det_now || fatal_now) begin
                errSticky <= 1'b1;
            end
        end
    end

endmodule
